// File: rtl/ram_dump.sv
// ram_dump: streams one channel of the capture RAM to the UART, oldest sample first
module ram_dump #(
  parameter int ENTRIES = 384,
  parameter int AW      = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_en,
  input  logic [2:0]    dump_chan,
  input  logic [AW-1:0] start_addr,
  output logic [AW-1:0] raddr,
  input  logic [7:0]    rdata1,
  input  logic [7:0]    rdata2,
  input  logic [7:0]    rdata3,
  input  logic [7:0]    rdata4,
  input  logic [7:0]    rdata5,
  output logic [7:0]    tx_data,
  output logic          trmt,
  input  logic          tx_done,
  output logic          busy,
  output logic          dump_done
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, LOAD, TX_WAIT} state_t;
  localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);
  state_t        r_state, w_next;
  logic [2:0]    r_chan, w_chan_n;
  logic [AW-1:0] r_raddr, w_raddr_n, r_cnt, w_cnt_n, w_start_addr, w_raddr_inc;
  logic [7:0]    r_tx_data, w_tx_data_n, w_rdata;
  logic          r_trmt, w_trmt_n, r_busy, w_busy_n, r_done, w_done_n;
  logic          w_req, w_valid, w_start, w_reject, w_adv, w_last, w_step;
  // A request arriving while dump_done is still high is dropped, so a new dump
  // only starts from a quiet IDLE cycle.
  assign w_req        = (r_state == IDLE) & dump_en & ~r_done;
  assign w_valid      = (dump_chan != 3'd0) & (dump_chan < 3'd6);
  assign w_start      = w_req & w_valid;
  assign w_reject     = w_req & ~w_valid;
  assign w_adv        = (r_state == TX_WAIT) & tx_done;
  assign w_last       = r_cnt == LAST;
  assign w_step       = w_adv & ~w_last;
  assign w_start_addr = ((AW+1)'(start_addr) >= (AW+1)'(ENTRIES)) ? '0 : start_addr;
  assign w_raddr_inc  = (r_raddr == LAST) ? '0 : r_raddr + 1'b1;
  assign w_rdata      = r_chan == 3'd1 ? rdata1 :
                        r_chan == 3'd2 ? rdata2 :
                        r_chan == 3'd3 ? rdata3 :
                        r_chan == 3'd4 ? rdata4 : rdata5;
  assign raddr     = r_raddr;
  assign tx_data   = r_tx_data;
  assign trmt      = r_trmt;
  assign busy      = r_busy;
  assign dump_done = r_done;
  // State and registered outputs, cleared asynchronously so a reset aborts a dump at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_chan    <= '0;
      r_raddr   <= '0;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_trmt    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_chan    <= w_chan_n;
      r_raddr   <= w_raddr_n;
      r_cnt     <= w_cnt_n;
      r_tx_data <= w_tx_data_n;
      r_trmt    <= w_trmt_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
    end
  end
  // Next state: RD_WAIT covers the one-cycle RAM latency, TX_WAIT waits on the UART
  always_comb begin
    w_next = w_start               ? RD_WAIT :
             r_state == RD_WAIT    ? LOAD :
             r_state == LOAD       ? TX_WAIT :
             w_adv                 ? (w_last ? IDLE : RD_WAIT) : r_state;
  end
  // Next values of the datapath and strobes; tx_data only changes in LOAD so it holds across TX_WAIT
  always_comb begin
    w_chan_n    = w_start ? dump_chan : r_chan;
    w_raddr_n   = w_start ? w_start_addr : w_step ? w_raddr_inc : r_raddr;
    w_cnt_n     = w_start ? '0 : w_step ? r_cnt + 1'b1 : r_cnt;
    w_tx_data_n = (r_state == LOAD) ? w_rdata : r_tx_data;
    w_trmt_n    = r_state == LOAD;
    w_busy_n    = w_start | (r_busy & ~(w_adv & w_last));
    w_done_n    = w_reject | (w_adv & w_last);
  end
endmodule

// File: doc/ram_dump.md
RAM_DUMP -- requirements
Module: ram_dump

Interface
REQ-001 SHALL provide parameter ENTRIES, default 384, the capture-RAM depth in samples per channel.
REQ-002 SHALL provide parameter AW, default 9, the RAM address width; ENTRIES <= 2**AW.
REQ-003 SHALL have port clk  input  1  system clock (the divided clk from clk_rst_smpl); the block has one clock only.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dump_en  input  1  single-cycle request to read out one channel.
REQ-006 SHALL have port dump_chan  input  3  channel select; 1..5 are valid.
REQ-007 SHALL have port start_addr  input  AW  oldest-sample address, i.e. the write pointer at capture end.
REQ-008 SHALL have port raddr  output  AW  read address shared by the five channel RAMs.
REQ-009 SHALL have ports rdata1..rdata5  input  8 each  RAM read data, valid one clk after raddr.
REQ-010 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-011 SHALL have port trmt  output  1  single-cycle strobe that starts a UART transmit.
REQ-012 SHALL have port tx_done  input  1  UART finished the current byte; may be level or pulse.
REQ-013 SHALL have port busy  output  1  high while a dump is in progress.
REQ-014 SHALL have port dump_done  output  1  single-cycle pulse after the last byte's tx_done.

Function
REQ-015 SHALL implement the FSM states IDLE, RD_WAIT, LOAD and TX_WAIT.
REQ-016 In IDLE with dump_en=1 and dump_chan in 1..5, SHALL latch dump_chan, load raddr<=start_addr, clear byte count, set busy, and go to RD_WAIT.
REQ-017 SHALL treat start_addr >= ENTRIES as 0.
REQ-018 In IDLE with dump_en=1 and dump_chan in {0,6,7}, SHALL perform no RAM read and no trmt, SHALL pulse dump_done in the next cycle, and SHALL keep busy low.
REQ-019 SHALL leave RD_WAIT for LOAD unconditionally after one cycle, covering the RAM read latency.
REQ-020 In LOAD, SHALL register tx_data<=rdata of the latched channel, assert trmt for exactly one cycle (the next one), and go to TX_WAIT.
REQ-021 With dump_en high in cycle N, the first trmt and its tx_data SHALL be valid in cycle N+3.
REQ-022 tx_data SHALL hold its value from the trmt cycle until the next LOAD.
REQ-023 In TX_WAIT, while tx_done=0, SHALL stay in TX_WAIT.
REQ-024 In TX_WAIT, on tx_done=1 when count < ENTRIES-1, SHALL increment count, advance raddr, and go to RD_WAIT.
REQ-025 SHALL advance raddr modulo ENTRIES: raddr==ENTRIES-1 SHALL wrap to 0, never to ENTRIES.
REQ-026 In TX_WAIT, on tx_done=1 when count == ENTRIES-1, SHALL pulse dump_done for one cycle, clear busy in the same cycle, and go to IDLE.
REQ-027 Exactly ENTRIES bytes SHALL be sent per dump, in order oldest to newest, starting at start_addr.
REQ-028 SHALL ignore dump_en while busy; the in-progress dump and its latched channel SHALL be unaffected.
REQ-029 SHALL ignore tx_done in IDLE, RD_WAIT and LOAD.
REQ-030 Back-to-back operation: tx_done and dump_done occurring in the same cycle as a new dump_en SHALL not start a new dump; the new dump_en SHALL be honored only from IDLE, in the cycle after dump_done.
REQ-031 SHALL assert trmt and dump_done at most one cycle at a time and never in the same cycle.

Reset
REQ-032 On rst_n low, SHALL go to IDLE asynchronously, with raddr=0, tx_data=0x00, trmt=0, busy=0, dump_done=0, count=0 and latched channel=0.
REQ-033 Reset mid-dump SHALL abort the dump without a dump_done pulse.
REQ-034 After reset release, SHALL require a fresh dump_en before starting any dump.

Verification
REQ-035 Basic dump: ENTRIES=8, start_addr=0, dump_chan=3, RAM3[i]=0x10+i, tx_done 5 cycles after each trmt -> bytes 0x10..0x17 in order, 8 trmt pulses, first trmt at N+3, one dump_done, busy low after.
REQ-036 Wrap: ENTRIES=8, start_addr=6 -> raddr sequence 6,7,0,1,2,3,4,5; bytes RAM[6],RAM[7],RAM[0]..RAM[5]; raddr never equals 8.
REQ-037 Invalid channel: dump_chan=0, then dump_chan=7 -> no trmt, busy stays 0, dump_done pulses 1 cycle after each dump_en.
REQ-038 Busy-ignore and tx_done hold: dump_en with dump_chan=5 pulsed while dumping channel 2 -> all bytes come from rdata2; tx_done held high 3 cycles -> only one byte advance per LOAD/TX_WAIT round.
REQ-039 Reset mid-dump: rst_n low after the 3rd byte -> outputs at reset values immediately (asynchronous), no dump_done; a new dump_en then restarts from start_addr with count 0.
REQ-040 Out-of-range start: ENTRIES=8, start_addr=12 -> dump starts at raddr 0; the first byte equals RAM[0].
